writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final pipeline stage: takes retiring results, performs the data-memory access for loads/stores,
//  and drives the register file write port (wen/wsel/wdat). Sits between execute and register file.
//  Stalls upstream via in_ready while a memory access is outstanding; latches halt as a sticky flag.
// PARAMETERS
//  DATA_W   32  width of data words, addresses and register write data
//  SEL_W    5   register select width (2**SEL_W registers; register 0 is hardwired zero)
//  CNT_W    16  width of the saturating memory-stall cycle counter
// PORTS
//  CLK          in   1       clock; all state updates on posedge
//  nRST         in   1       reset, synchronous, active-low
//  in_valid     in   1       retiring instruction present
//  in_ready     out  1       unit accepts in_valid this cycle
//  in_memread   in   1       instruction is a load
//  in_memwrite  in   1       instruction is a store
//  in_halt      in   1       instruction is halt
//  in_wsel      in   SEL_W   destination register
//  in_result    in   DATA_W  ALU result (write data, or memory address for ld/st)
//  in_store     in   DATA_W  store data
//  dmemREN      out  1       data memory read request
//  dmemWEN      out  1       data memory write request
//  dmemaddr     out  DATA_W  memory address
//  dmemstore    out  DATA_W  memory store data
//  dhit         in   1       memory completes request this cycle
//  dmemload     in   DATA_W  load data, valid when dhit
//  wen          out  1       register file write enable (1-cycle pulse)
//  wsel         out  SEL_W   register file write select
//  wdat         out  DATA_W  register file write data
//  halt         out  1       sticky halt
//  stall_cnt    out  CNT_W   total cycles spent in MEM, saturating
// BEHAVIOUR
//  - One clock CLK; reset nRST synchronous, active-low. Reset: state IDLE, all outputs 0.
//  - FSM states IDLE, MEM, HALTED. in_ready = (state==IDLE). Request outputs combinational from captured regs.
//  - IDLE, in_valid=1:
//     in_halt=1 -> HALTED; halt priority over mem flags; no write, no mem access.
//     memread|memwrite -> capture addr/store/wsel/type, MEM next cycle.
//     else -> next cycle wen=1, wsel=in_wsel, wdat=in_result.
//  - MEM: dmemREN=captured load, dmemWEN=captured store, dmemaddr/dmemstore held stable.
//     stall_cnt += 1 each MEM cycle, saturates at all-ones.
//     dhit=1 -> IDLE next cycle; load: wen=1, wdat=dmemload sampled on that edge; store: no write.
//     dhit=0 -> remain in MEM, requests held.
//  - wen is a single-cycle pulse; deasserts the cycle after unless a new write retires.
//  - wen forced 0 when destination is register 0 (wsel/wdat still update).
//  - Both in_memread and in_memwrite set: treat as load only, dmemWEN=0.
//  - HALTED: halt=1, in_ready=0, no requests; exits only on reset.
//  - Reset mid-MEM: requests drop after the reset edge, pending load discarded, stall_cnt cleared.
//  - in_valid ignored whenever in_ready=0; upstream holds its inputs.
// CONFIGURATION
//  WB_FORWARD_EN defined: extra outputs fwd_valid(1), fwd_sel(SEL_W), fwd_dat(DATA_W),
//   combinational copy of wen/wsel/wdat for execute-stage bypass.
//  fwd_valid is also asserted combinationally in IDLE for a non-mem, non-halt in_valid with in_wsel!=0:
//   fwd_sel=in_wsel, fwd_dat=in_result.
//  Undefined: ports absent, no bypass logic.
// TESTING
//  ALU op wsel=3 result=0x1234 -> next cycle wen=1 wsel=3 wdat=0x1234; following cycle wen=0.
//  Load addr=0x40 wsel=5, dhit after 3 cycles with 0xDEADBEEF
//   -> dmemREN=1 for 3 cycles, in_ready=0, stall_cnt=3, then wen=1 wdat=0xDEADBEEF.
//  Store addr=0x80 data=0xA5A5 with dhit on the first MEM cycle -> dmemWEN=1 one cycle,
//   dmemaddr=0x80, no wen.
//  ALU op wsel=0 result=0xFFFF -> wen stays 0; halt with memread=1 -> halt=1, no request, in_ready=0.
//  nRST low during MEM -> next cycle dmemREN=0, state IDLE, stall_cnt=0, no wen.
//  Force CNT_W=2 with a 6-cycle load stall -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Data-memory request bus between the writeback unit (master) and data memory (slave).
interface writeback_unit_if #(
   parameter int DATA_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [DATA_W-1:0] dmemaddr;
   logic [DATA_W-1:0] dmemstore;
   logic              dhit;
   logic [DATA_W-1:0] dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: data-memory access for loads/stores, register file write port, sticky halt.
// Define WB_FORWARD_EN to add the fwd_valid/fwd_sel/fwd_dat execute-stage bypass outputs.
module writeback_unit #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_memread,
   input  logic                 in_memwrite,
   input  logic                 in_halt,
   input  logic [SEL_W-1:0]     in_wsel,
   input  logic [DATA_W-1:0]    in_result,
   input  logic [DATA_W-1:0]    in_store,
   writeback_unit_if.master     dmem,
   output logic                 wen,
   output logic [SEL_W-1:0]     wsel,
   output logic [DATA_W-1:0]    wdat,
   output logic                 halt,
   output logic [CNT_W-1:0]     stall_cnt
`ifdef WB_FORWARD_EN
   ,
   output logic                 fwd_valid,
   output logic [SEL_W-1:0]     fwd_sel,
   output logic [DATA_W-1:0]    fwd_dat
`endif
);

   typedef enum logic [1:0] {IDLE, MEM, HALTED} state_t;

   state_t state, next_state;

   logic              accept;
   logic              wants_mem;
   logic              alu_retire;

   logic [DATA_W-1:0] addr_p0;
   logic [DATA_W-1:0] store_p0;
   logic [SEL_W-1:0]  sel_p0;
   logic              load_p0;
   logic              storeop_p0;

   logic              vld_p1;
   logic [SEL_W-1:0]  sel_p1;
   logic [DATA_W-1:0] dat_p1;

   logic [CNT_W-1:0]  cnt_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign accept     = (state == IDLE) && in_valid;
   assign wants_mem  = in_memread || in_memwrite;
   assign alu_retire = accept && !in_halt && !wants_mem;

   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_halt)        next_state = HALTED;
               else if (wants_mem) next_state = MEM;
            end
         end
         MEM:     if (dmem.dhit) next_state = IDLE;
         HALTED:  next_state = HALTED;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready       = (state == IDLE);
      halt           = (state == HALTED);
      dmem.dmemREN   = (state == MEM) && load_p0;
      dmem.dmemWEN   = (state == MEM) && storeop_p0;
      dmem.dmemaddr  = (state == MEM) ? addr_p0  : '0;
      dmem.dmemstore = (state == MEM) ? store_p0 : '0;
`ifdef WB_FORWARD_EN
      // The retiring ALU result is younger than the registered write, so it wins.
      if (alu_retire && (in_wsel != '0)) begin
         fwd_valid = 1'b1;
         fwd_sel   = in_wsel;
         fwd_dat   = in_result;
      end else begin
         fwd_valid = vld_p1;
         fwd_sel   = sel_p1;
         fwd_dat   = dat_p1;
      end
`endif
   end

   // Stage p0: memory request captured on acceptance; stateless data, gated by state.
   always_ff @(posedge CLK) begin
      if (accept && !in_halt && wants_mem) begin
         addr_p0    <= in_result;
         store_p0   <= in_store;
         sel_p0     <= in_wsel;
         load_p0    <= in_memread;
         storeop_p0 <= in_memwrite && !in_memread;
      end
   end

   // Stage p1: register file write port, one-cycle enable pulse.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         vld_p1 <= 1'b0;
         sel_p1 <= '0;
         dat_p1 <= '0;
      end else begin
         vld_p1 <= 1'b0;
         if (alu_retire) begin
            vld_p1 <= (in_wsel != '0);
            sel_p1 <= in_wsel;
            dat_p1 <= in_result;
         end else if ((state == MEM) && dmem.dhit && load_p0) begin
            vld_p1 <= (sel_p0 != '0);
            sel_p1 <= sel_p0;
            dat_p1 <= dmem.dmemload;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST)              cnt_q <= '0;
      else if (state == MEM)  cnt_q <= sat_inc(cnt_q);
   end

   assign wen       = vld_p1;
   assign wsel      = sel_p1;
   assign wdat      = dat_p1;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized scoreboard bench for writeback_unit; a second instance with CNT_W=2 covers counter saturation.
module tb_writeback_unit;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 5;
   localparam int CNT_W  = 16;

   logic              CLK = 1'b0;
   logic              nRST = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_memread = 1'b0;
   logic              in_memwrite = 1'b0;
   logic              in_halt = 1'b0;
   logic [SEL_W-1:0]  in_wsel = '0;
   logic [DATA_W-1:0] in_result = '0;
   logic [DATA_W-1:0] in_store = '0;
   logic              dhit = 1'b0;
   logic [DATA_W-1:0] dmemload = '0;

   logic              in_ready, wen, halt;
   logic [SEL_W-1:0]  wsel;
   logic [DATA_W-1:0] wdat;
   logic [CNT_W-1:0]  stall_cnt;

   logic              in_ready2, wen2, halt2;
   logic [SEL_W-1:0]  wsel2;
   logic [DATA_W-1:0] wdat2;
   logic [1:0]        stall_cnt2;

`ifdef WB_FORWARD_EN
   logic              fwd_valid, fwd_valid2;
   logic [SEL_W-1:0]  fwd_sel, fwd_sel2;
   logic [DATA_W-1:0] fwd_dat, fwd_dat2;
`endif

   writeback_unit_if #(.DATA_W(DATA_W)) dm ();
   writeback_unit_if #(.DATA_W(DATA_W)) dm2 ();

   assign dm.dhit      = dhit;
   assign dm.dmemload  = dmemload;
   assign dm2.dhit     = dhit;
   assign dm2.dmemload = dmemload;

   always #5 CLK = ~CLK;

   writeback_unit #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
      .in_memread(in_memread), .in_memwrite(in_memwrite), .in_halt(in_halt),
      .in_wsel(in_wsel), .in_result(in_result), .in_store(in_store),
      .dmem(dm), .wen(wen), .wsel(wsel), .wdat(wdat), .halt(halt), .stall_cnt(stall_cnt)
`ifdef WB_FORWARD_EN
      , .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_dat(fwd_dat)
`endif
   );

   writeback_unit #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(2)) dut_sat (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready2),
      .in_memread(in_memread), .in_memwrite(in_memwrite), .in_halt(in_halt),
      .in_wsel(in_wsel), .in_result(in_result), .in_store(in_store),
      .dmem(dm2), .wen(wen2), .wsel(wsel2), .wdat(wdat2), .halt(halt2), .stall_cnt(stall_cnt2)
`ifdef WB_FORWARD_EN
      , .fwd_valid(fwd_valid2), .fwd_sel(fwd_sel2), .fwd_dat(fwd_dat2)
`endif
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] dat;
   } wr_t;

   wr_t    exp_q[$];
   longint total_stall = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return (v > m) ? m : v;
   endfunction

   // Monitor: every register file write must match the oldest expected write.
   always @(negedge CLK) begin
      wr_t e;
      if (wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wen", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_sel", 64'(wsel), 64'(e.sel));
            chk("wb_dat", 64'(wdat), 64'(e.dat));
         end
      end
   end

   task automatic issue_alu(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] res);
      wr_t e;
      chk("alu_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_memread = 1'b0; in_memwrite = 1'b0; in_halt = 1'b0;
      in_wsel = sel; in_result = res; in_store = $urandom;
      if (sel != '0) begin
         e.sel = sel; e.dat = res;
         exp_q.push_back(e);
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   task automatic issue_mem(input logic rd, input logic wr, input logic [DATA_W-1:0] addr,
                            input logic [DATA_W-1:0] st, input logic [SEL_W-1:0] sel,
                            input int lat, input logic [DATA_W-1:0] ldval);
      logic ldop, stop;
      wr_t  e;
      ldop = rd;
      stop = wr && !rd;
      chk("mem_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_memread = rd; in_memwrite = wr; in_halt = 1'b0;
      in_wsel = sel; in_result = addr; in_store = st;
      @(posedge CLK); #1;
      // in_valid stays high while in_ready is low; the unit must ignore it.
      for (int c = 1; c <= lat; c++) begin
         chk("mem_ren", 64'(dm.dmemREN), 64'(ldop));
         chk("mem_wen", 64'(dm.dmemWEN), 64'(stop));
         chk("mem_addr", 64'(dm.dmemaddr), 64'(addr));
         if (stop) chk("mem_store", 64'(dm.dmemstore), 64'(st));
         chk("mem_ready_low", 64'(in_ready), 64'd0);
         if (c == lat) begin
            dhit = 1'b1;
            dmemload = ldval;
            if (ldop && sel != '0) begin
               e.sel = sel; e.dat = ldval;
               exp_q.push_back(e);
            end
         end else begin
            dmemload = $urandom;
         end
         @(posedge CLK); #1;
         dhit = 1'b0;
      end
      in_valid = 1'b0;
      total_stall += lat;
      chk("stall_cnt", 64'(stall_cnt), 64'(sat(total_stall, CNT_W)));
      chk("stall_cnt_sat2", 64'(stall_cnt2), 64'(sat(total_stall, 2)));
      chk("ready_after_mem", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int kind;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_wen", 64'(wen), 64'd0);
      chk("rst_wsel", 64'(wsel), 64'd0);
      chk("rst_wdat", 64'(wdat), 64'd0);
      chk("rst_ren", 64'(dm.dmemREN), 64'd0);
      chk("rst_dwen", 64'(dm.dmemWEN), 64'd0);
      chk("rst_addr", 64'(dm.dmemaddr), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      nRST = 1'b1;
      @(posedge CLK); #1;
      chk("rst_ready", 64'(in_ready), 64'd1);

      // ALU write then pulse end
      issue_alu(5'd3, 32'h1234);
      chk("alu_wen", 64'(wen), 64'd1);
      chk("alu_wsel", 64'(wsel), 64'd3);
      chk("alu_wdat", 64'(wdat), 64'h1234);
      @(posedge CLK); #1;
      chk("alu_wen_drop", 64'(wen), 64'd0);

      // Load with three stall cycles
      issue_mem(1'b1, 1'b0, 32'h40, 32'h0, 5'd5, 3, 32'hDEADBEEF);
      chk("ld_wen", 64'(wen), 64'd1);
      chk("ld_wdat", 64'(wdat), 64'hDEADBEEF);
      chk("ld_cnt3", 64'(stall_cnt), 64'd3);

      // Store completing on the first memory cycle
      issue_mem(1'b0, 1'b1, 32'h80, 32'hA5A5, 5'd7, 1, 32'h0);
      chk("st_no_wen", 64'(wen), 64'd0);

      // Write to register zero is suppressed but the port still updates
      issue_alu(5'd0, 32'hFFFF);
      chk("r0_wen", 64'(wen), 64'd0);
      chk("r0_wsel", 64'(wsel), 64'd0);
      chk("r0_wdat", 64'(wdat), 64'hFFFF);

      // Load and store flags together act as a load
      issue_mem(1'b1, 1'b1, 32'h100, 32'h55, 5'd9, 2, 32'hCAFE0001);

      // Back-to-back ALU ops
      issue_alu(5'd1, 32'h11);
      issue_alu(5'd2, 32'h22);

      repeat (40) begin
         kind = $urandom_range(0, 3);
         if (kind <= 1)
            issue_alu(5'($urandom_range(0, 31)), $urandom);
         else if (kind == 2)
            issue_mem(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                      5'($urandom_range(0, 31)), $urandom_range(1, 6), $urandom);
         else
            issue_mem(1'b0, 1'b1, $urandom, $urandom,
                      5'($urandom_range(0, 31)), $urandom_range(1, 6), $urandom);
      end
      @(posedge CLK); #1;

      // Reset in the middle of a load: pending load discarded
      in_valid = 1'b1; in_memread = 1'b1; in_memwrite = 1'b0; in_halt = 1'b0;
      in_wsel = 5'd12; in_result = 32'h200;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      chk("midrst_ren_before", 64'(dm.dmemREN), 64'd1);
      nRST = 1'b0;
      in_valid = 1'b0;
      @(posedge CLK); #1;
      chk("midrst_ren", 64'(dm.dmemREN), 64'd0);
      chk("midrst_cnt", 64'(stall_cnt), 64'd0);
      chk("midrst_cnt2", 64'(stall_cnt2), 64'd0);
      chk("midrst_wen", 64'(wen), 64'd0);
      nRST = 1'b1;
      total_stall = 0;
      @(posedge CLK); #1;
      chk("midrst_ready", 64'(in_ready), 64'd1);

      // Six-cycle stall saturates the 2-bit counter at 3
      issue_mem(1'b1, 1'b0, 32'h300, 32'h0, 5'd4, 6, 32'h600D600D);
      chk("sat6_cnt16", 64'(stall_cnt), 64'd6);
      chk("sat6_cnt2", 64'(stall_cnt2), 64'd3);

      // Halt beats the load flag and is sticky
      in_valid = 1'b1; in_halt = 1'b1; in_memread = 1'b1; in_memwrite = 1'b0;
      in_wsel = 5'd9; in_result = 32'h44;
      @(posedge CLK); #1;
      in_valid = 1'b0; in_halt = 1'b0;
      chk("halt_set", 64'(halt), 64'd1);
      chk("halt_ready", 64'(in_ready), 64'd0);
      chk("halt_ren", 64'(dm.dmemREN), 64'd0);
      chk("halt_dwen", 64'(dm.dmemWEN), 64'd0);
      in_valid = 1'b1; in_memread = 1'b0; in_wsel = 5'd6; in_result = 32'h77;
      repeat (3) @(posedge CLK);
      #1;
      in_valid = 1'b0;
      chk("halt_sticky", 64'(halt), 64'd1);
      chk("halt_no_wen", 64'(wen), 64'd0);
      nRST = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      chk("halt_cleared", 64'(halt), 64'd0);
      chk("halt_ready_back", 64'(in_ready), 64'd1);

      repeat (2) @(posedge CLK);
      #1;
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
